instr_decode_buffer: RTL and testbench
======================================

# instr_decode_buffer

Parametrised IF/ID decoupling buffer with field extraction and immediate generation, sitting between instruction fetch and the decode/register-read stage of the 5-stage RISC-V pipeline. Accepts fetched instruction words with their PC over a valid/ready handshake. Splits each word into opcode, register addresses and funct fields, classifies its format, and builds the sign-extended immediate. Stores up to DEPTH decoded entries in order and supports a single-cycle flush for branch redirects.

## Interface
- XLEN, 32: data/PC/immediate width; must be ≥ 32.
- DEPTH, 4: entry count; power of two, ≥ 2.
- CW, $clog2(DEPTH+1): width of `count`; derived, not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- flush  in  1  discard all entries.
- in_valid  in  1  fetch word present.
- in_ready  out  1  buffer can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry present.
- out_ready  in  1  decode stage consumes head.
- out_pc  out  XLEN  head PC.
- out_instr  out  32  head raw word.
- opcode  out  7  instr[6:0].
- rd_addr  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1_addr  out  5  instr[19:15].
- rs2_addr  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- fmt  out  3  FMT_R/I/S/B/U/J/ILLEGAL.
- imm  out  XLEN  sign-extended immediate.
- count  out  CW  occupied entries.

## Operation
- Push when in_valid && in_ready && !flush. Decode happens at push time; the decoded fields, fmt and imm are stored with the PC and raw word.
- Pop when out_valid && out_ready && !flush. The head pointer advances.
- Push and pop in the same cycle: count is unchanged. Both pointers advance and wrap modulo DEPTH.
- Flush: read pointer, write pointer and count go to 0. A push in the same cycle is discarded, and any pop in that cycle is ignored.
- Format classification by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else, including instr[1:0] ≠ 11 → ILLEGAL
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R and ILLEGAL: imm = 0.
- Field outputs are always the raw bit slices of the head word, regardless of fmt.
- Empty buffer: all data outputs (out_pc … imm) read 0 and fmt reads FMT_ILLEGAL. Consumers qualify on out_valid.

## Timing
- Reset values: out_valid 0, in_ready 1, count 0, all data outputs 0, fmt FMT_ILLEGAL. Pointers are 0.
- Reset asserted mid-operation clears everything immediately and asynchronously. There is no drain.
- Latency: a word pushed at edge N is visible on the outputs with out_valid=1 after edge N. Minimum one cycle, no bypass.
- in_ready = (count ≠ DEPTH) and out_valid = (count ≠ 0). Both depend on registered state only. There is no combinational path from any input to any output.
- When full, in_ready=0 even if out_ready=1, so a push cannot be accepted in the same cycle as a pop from a full buffer.
- in_instr/in_pc must remain stable while in_valid=1 && in_ready=0. The bench checks this; the RTL does not rely on it.
- Flush takes effect at the next edge: count=0 and out_valid=0 after that edge.

## Structure
- A shared package `rv_decode_pkg` holds:
  - FMT_* localparams (3-bit): R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
  - OP_* opcode constants
  - the decoded-entry struct {pc, instr, fmt, imm}
- Sub-module `instr_field_decode` is purely combinational and parametrised by XLEN. It maps instr to fmt and imm, is instantiated once at the push side, and is reused later by the EX stage.
- The storage array is DEPTH entries with no reset. Pointers and count are reset.

## Test plan
- Reset with in_valid=1 → in_ready=1, out_valid=0, count=0, imm=0, fmt=ILLEGAL; nothing is pushed while rst=1.
- Push 0x00500093 → next cycle out_valid=1, opcode=0x13, rd_addr=1, rs1_addr=0, funct3=0, fmt=I, imm=5, out_pc equals pushed PC.
- Push 0xFE208EE3 → fmt=B, rs1_addr=1, rs2_addr=2, imm=0xFFFFFFFC (XLEN=32). Push 0x0000007F → fmt=ILLEGAL, imm=0.
- DEPTH=4, out_ready=0, push five words → in_ready=0 after the fourth, count=4, fifth not stored. Raise out_ready → words drain in push order, count reaches 0.
- Count=2 with push and pop in the same cycle for 10 cycles → count stays 2, output order matches input order across pointer wrap.
- Count=3, flush=1 with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle word never appears.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32/RV64 decode definitions: format codes, major opcodes and the
// decoded-entry record carried between fetch and decode.
package rv_decode_pkg;

    // Widest supported XLEN; narrower pipelines keep the low bits of pc/imm.
    localparam int MAX_XLEN = 64;

    localparam logic [2:0] FMT_R       = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic [2:0]          fmt;
        logic [MAX_XLEN-1:0] imm;
    } dec_entry_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational format classifier and immediate generator for one RISC-V
// instruction word; shared by the IF/ID buffer and the EX stage.
module instr_field_decode
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // NOTE: every output of this always_comb gets a default before the case, so no latch can be inferred.
    always_comb begin
        fmt   = FMT_ILLEGAL;
        imm32 = '0;
        case (instr[6:0])
            OP_OP: fmt = FMT_R;
            OP_OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Every 32-bit immediate already carries instr[31] in bit 31, so widening is a plain sign extension.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_buffer.sv
// IF/ID decoupling FIFO: decodes fetched words on entry and presents the
// oldest decoded entry to the decode/register-read stage.
module instr_decode_buffer
    import rv_decode_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd_addr,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [6:0]      funct7,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic [CW-1:0]   count
);

    localparam int PW = $clog2(DEPTH);

    dec_entry_t      mem [DEPTH];
    dec_entry_t      head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            push;
    logic            pop;

    instr_field_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; stale slots are never observed because outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc:    MAX_XLEN'(in_pc),
                             instr: in_instr,
                             fmt:   dec_fmt,
                             imm:   MAX_XLEN'(dec_imm)};
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pc    = out_valid ? XLEN'(head.pc)  : '0;
    assign imm       = out_valid ? XLEN'(head.imm) : '0;
    assign out_instr = out_valid ? head.instr      : '0;
    assign fmt       = out_valid ? head.fmt        : FMT_ILLEGAL;
    assign opcode    = out_instr[6:0];
    assign rd_addr   = out_instr[11:7];
    assign funct3    = out_instr[14:12];
    assign rs1_addr  = out_instr[19:15];
    assign rs2_addr  = out_instr[24:20];
    assign funct7    = out_instr[31:25];

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Randomised and directed checks of instr_decode_buffer against a queue model
// whose decode is computed from the ISA immediate definitions arithmetically.
module tb_instr_decode_buffer;
    import rv_decode_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [6:0]      opcode;
    logic [4:0]      rd_addr;
    logic [2:0]      funct3;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [CW-1:0]   count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } word_t;

    word_t q[$];

    always #5 clk = ~clk;

    instr_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rd_addr(rd_addr), .funct3(funct3), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .funct7(funct7), .fmt(fmt), .imm(imm), .count(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        case (w[6:0])
            7'h33:                      return FMT_R;
            7'h13, 7'h03, 7'h67, 7'h73: return FMT_I;
            7'h23:                      return FMT_S;
            7'h63:                      return FMT_B;
            7'h37, 7'h17:               return FMT_U;
            7'h6f:                      return FMT_J;
            default:                    return FMT_ILLEGAL;
        endcase
    endfunction

    // Immediate value as a signed integer: instr[31] carries the negative top weight.
    function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w);
        longint v;
        longint s;
        s = w[31] ? 1 : 0;
        case (ref_fmt(w))
            FMT_I: v = -s * 2048 + longint'(w[30:20]);
            FMT_S: v = -s * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:7]);
            FMT_B: v = -s * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            FMT_U: v = -s * 64'sh8000_0000 + longint'(w[30:12]) * 4096;
            FMT_J: v = -s * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            default: v = 0;
        endcase
        return XLEN'(v);
    endfunction

    task automatic compare();
        word_t h;
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            check("out_pc", 64'(out_pc), 64'(h.pc));
            check("out_instr", 64'(out_instr), 64'(h.instr));
            check("opcode", 64'(opcode), 64'(h.instr & 32'h7f));
            check("rd_addr", 64'(rd_addr), 64'((h.instr >> 7) & 32'h1f));
            check("funct3", 64'(funct3), 64'((h.instr >> 12) & 32'h7));
            check("rs1_addr", 64'(rs1_addr), 64'((h.instr >> 15) & 32'h1f));
            check("rs2_addr", 64'(rs2_addr), 64'((h.instr >> 20) & 32'h1f));
            check("funct7", 64'(funct7), 64'(h.instr >> 25));
            check("fmt", 64'(fmt), 64'(ref_fmt(h.instr)));
            check("imm", 64'(imm), 64'(ref_imm(h.instr)));
        end else begin
            check("empty_pc", 64'(out_pc), 64'd0);
            check("empty_instr", 64'(out_instr), 64'd0);
            check("empty_imm", 64'(imm), 64'd0);
            check("empty_fmt", 64'(fmt), 64'(FMT_ILLEGAL));
        end
    endtask

    // Model the edge from the inputs currently applied, then compare at the following negedge.
    task automatic step();
        bit    do_push;
        bit    do_pop;
        word_t w;
        do_push = in_valid && (q.size() != DEPTH) && !flush;
        do_pop  = (q.size() != 0) && out_ready && !flush;
        w.instr = in_instr;
        w.pc    = in_pc;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(w);
        end
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        bit hold;
        bit hold_next;

        // Reset held with a word on offer: nothing may be stored.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0000_1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare();
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fmt", 64'(fmt), 64'(FMT_ILLEGAL));
        rst = 1'b0;

        drive(1, 32'h00500093, 32'h0000_1000, 0, 0);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_opcode", 64'(opcode), 64'h13);
        check("addi_rd", 64'(rd_addr), 64'd1);
        check("addi_rs1", 64'(rs1_addr), 64'd0);
        check("addi_fmt", 64'(fmt), 64'(FMT_I));
        check("addi_imm", 64'(imm), 64'd5);
        check("addi_pc", 64'(out_pc), 64'h1000);

        drive(1, 32'hFE208EE3, 32'h0000_1004, 1, 0);
        check("bne_fmt", 64'(fmt), 64'(FMT_B));
        check("bne_rs1", 64'(rs1_addr), 64'd1);
        check("bne_rs2", 64'(rs2_addr), 64'd2);
        check("bne_imm", 64'(imm), 64'hFFFF_FFFC);

        drive(1, 32'h0000007F, 32'h0000_1008, 1, 0);
        check("ill_fmt", 64'(fmt), 64'(FMT_ILLEGAL));
        check("ill_imm", 64'(imm), 64'd0);
        drive(0, 32'h0, 32'h0, 1, 0);

        // Fill past capacity with the consumer stalled, then drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1, rand_instr(), 32'h2000 + 32'(i * 4), 0, 0);
            if (i == 3) begin
                check("full_in_ready", 64'(in_ready), 64'd0);
                check("full_count", 64'(count), 64'd4);
            end
        end
        check("fifth_dropped", 64'(count), 64'd4);
        repeat (DEPTH + 1) drive(0, 32'h0, 32'h0, 1, 0);
        check("drained_count", 64'(count), 64'd0);

        // Steady push+pop at count 2 across pointer wrap.
        drive(1, rand_instr(), 32'h3000, 0, 0);
        drive(1, rand_instr(), 32'h3004, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, rand_instr(), 32'h3008 + 32'(i * 4), 1, 0);
            check("wrap_count", 64'(count), 64'd2);
        end
        repeat (3) drive(0, 32'h0, 32'h0, 1, 0);

        // Flush with a word on offer: that word is discarded.
        for (int i = 0; i < 3; i++) drive(1, rand_instr(), 32'h4000 + 32'(i * 4), 0, 0);
        drive(1, 32'h00C00513, 32'h4ABC, 1, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1, 32'h00100113, 32'h5000, 0, 0);
        check("post_flush_instr", 64'(out_instr), 64'h0010_0113);
        drive(0, 32'h0, 32'h0, 1, 0);

        // Random traffic; a stalled word is held until accepted.
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_instr = rand_instr();
                in_pc    = $urandom();
            end
            out_ready = ($urandom_range(0, 9) < 5);
            flush     = ($urandom_range(0, 49) == 0);
            hold_next = in_valid && (q.size() == DEPTH);
            step();
            hold = hold_next;
        end

        // Asynchronous reset between edges clears state immediately.
        drive(1, rand_instr(), 32'h6000, 0, 0);
        drive(1, rand_instr(), 32'h6004, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_fmt", 64'(fmt), 64'(FMT_ILLEGAL));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
